// File: rtl/texture_block_packer_rgba8888_pkg.sv
// Shared texture definitions: RGBA5652 input layout, RGBA8888 lanes and block geometry.
package texture_block_packer_rgba8888_pkg;

  localparam int unsigned R5_W             = 5;
  localparam int unsigned G6_W             = 6;
  localparam int unsigned B5_W             = 5;
  localparam int unsigned A2_W             = 2;
  localparam int unsigned TEXEL_IN_W       = 18;
  localparam int unsigned TEXEL_W          = 32;
  localparam int unsigned LANE_W           = 8;
  localparam int unsigned TEXELS_PER_BLOCK = 16;
  localparam int unsigned BLOCK_BITS       = 512;
  localparam int unsigned CNT_W            = $clog2(TEXELS_PER_BLOCK);

  localparam int unsigned R5_LSB = 13;
  localparam int unsigned G6_LSB = 7;
  localparam int unsigned B5_LSB = 2;
  localparam int unsigned A2_LSB = 0;

  localparam int unsigned R8_OFF = 0;
  localparam int unsigned G8_OFF = 8;
  localparam int unsigned B8_OFF = 16;
  localparam int unsigned A8_OFF = 24;

  typedef struct packed {
    logic [R5_W-1:0] r;
    logic [G6_W-1:0] g;
    logic [B5_W-1:0] b;
    logic [A2_W-1:0] a;
  } rgba5652_t;

endpackage

// File: rtl/texture_block_packer_rgba8888_expand.sv
// Combinational RGBA5652 -> RGBA8888 expansion by MSB replication.
module texel_expand_5652_to_8888
  import texture_block_packer_rgba8888_pkg::*;
(
  input  logic [TEXEL_IN_W-1:0] texel_i,
  output logic [TEXEL_W-1:0]    texel_c_o
);

  rgba5652_t px;

  assign px = rgba5652_t'(texel_i);

  always_comb begin
    texel_c_o = '0;
    texel_c_o[R8_OFF +: LANE_W] = {px.r, px.r[4:2]};
    texel_c_o[G8_OFF +: LANE_W] = {px.g, px.g[5:4]};
    texel_c_o[B8_OFF +: LANE_W] = {px.b, px.b[4:2]};
    texel_c_o[A8_OFF +: LANE_W] = {4{px.a}};
  end

endmodule

// File: rtl/texture_block_packer_rgba8888.sv
// Packs 16 expanded texels into 512-bit blocks through a ping-pong buffer
// so intake continues while a finished block waits for the SDRAM writer.
module texture_block_packer_rgba8888
  import texture_block_packer_rgba8888_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic [ADDR_W-1:0]     in_block_addr,
  input  logic [TEXEL_IN_W-1:0] in_rgba5652,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_BITS-1:0] out_block_data,
  output logic [ADDR_W-1:0]     out_block_addr,
  output logic                  resync_err
);

  logic [1:0][TEXELS_PER_BLOCK-1:0][TEXEL_W-1:0] buf_q;
  logic [1:0][ADDR_W-1:0]                        addr_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       full_q, full_d;
  logic             resync_q, resync_d;

  logic             accept;
  logic             drain;
  logic [CNT_W-1:0] slot;
  logic [TEXEL_W-1:0] texel8888;

  texel_expand_5652_to_8888 u_expand (
    .texel_i   (in_rgba5652),
    .texel_c_o (texel8888)
  );

  assign in_ready = !full_q[wr_sel_q];
  assign accept   = in_valid && in_ready;
  assign drain    = full_q[rd_sel_q] && out_ready;
  // A first texel always restarts at slot 0, discarding any partial block.
  assign slot     = in_first ? '0 : cnt_q;

  always_comb begin
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    full_d   = full_q;
    resync_d = 1'b0;
    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
    // Fill completion only targets a non-full buffer, never the one draining.
    if (accept) begin
      if (slot == CNT_W'(TEXELS_PER_BLOCK - 1)) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
        cnt_d            = '0;
      end else begin
        cnt_d = slot + CNT_W'(1);
      end
      resync_d = in_first && (cnt_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= 2'b00;
      resync_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      resync_q <= resync_d;
    end
  end

  // Payload storage is deliberately not reset; full flags gate its visibility.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[wr_sel_q][slot] <= texel8888;
      if (in_first) begin
        addr_q[wr_sel_q] <= in_block_addr;
      end
    end
  end

  assign out_valid      = full_q[rd_sel_q];
  assign out_block_data = buf_q[rd_sel_q];
  assign out_block_addr = addr_q[rd_sel_q];
  assign resync_err     = resync_q;

endmodule

// File: tb/tb_texture_block_packer_rgba8888.sv
// Directed scoreboard bench for texture_block_packer_rgba8888.
module tb_texture_block_packer_rgba8888;

  localparam int unsigned ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_first = 1'b0;
  logic [ADDR_W-1:0] in_block_addr = '0;
  logic [17:0]       in_rgba5652 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [511:0]      out_block_data;
  logic [ADDR_W-1:0] out_block_addr;
  logic              resync_err;

  always #5 clk = ~clk;

  texture_block_packer_rgba8888 #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_first       (in_first),
    .in_block_addr  (in_block_addr),
    .in_rgba5652    (in_rgba5652),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_block_data (out_block_data),
    .out_block_addr (out_block_addr),
    .resync_err     (resync_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [511:0]      data;
  } blk_t;

  blk_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            m_cnt = 0;
  logic [23:0]   m_addr = '0;
  logic [511:0]  m_data = '0;
  logic          exp_resync = 1'b0;
  int            drains = 0;
  int            resyncs = 0;

  function automatic logic [31:0] ref_expand(input logic [17:0] t);
    int r, g, b, a;
    r = int'(t[17:13]);
    g = int'(t[12:7]);
    b = int'(t[6:2]);
    a = int'(t[1:0]);
    ref_expand = {8'(a * 85), 8'((b << 3) | (b >> 2)),
                  8'((g << 2) | (g >> 4)), 8'((r << 3) | (r >> 2))};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept();
    if (in_first) begin
      m_cnt  = 0;
      m_addr = in_block_addr;
    end
    m_data[m_cnt*32 +: 32] = ref_expand(in_rgba5652);
    m_cnt++;
    if (m_cnt == 16) begin
      exp_q.push_back('{m_addr, m_data});
      m_cnt = 0;
    end
  endtask

  // One clock: check outputs on the falling edge, update the model, step past the rising edge.
  task automatic cycle(output logic acc);
    blk_t b;
    @(negedge clk);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    check("resync_err", resync_err, exp_resync);
    if (resync_err) resyncs++;
    acc = in_valid && in_ready;
    if (out_valid && out_ready && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      check("blk_addr", out_block_addr, b.addr);
      check("blk_data", out_block_data, b.data);
      drains++;
    end
    exp_resync = acc && in_first && (m_cnt != 0);
    if (acc) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic first, input logic [23:0] a, input logic [17:0] d);
    logic acc;
    int   guard;
    in_valid      = 1'b1;
    in_first      = first;
    in_block_addr = a;
    in_rgba5652   = d;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      cycle(acc);
      guard++;
    end
    check("send_accepted", acc, 1'b1);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_cnt      = 0;
    exp_resync = 1'b0;
  endtask

  task automatic drive_texel(input int n);
    in_valid      = 1'b1;
    in_first      = (n % 16) == 0;
    in_block_addr = 24'h000A00 + 24'((n / 16) << 8);
    in_rgba5652   = 18'($urandom);
  endtask

  initial begin
    logic         acc;
    int           acc_cnt, guard, d0, r0;
    logic [511:0] mask;

    // Reset values
    do_reset();
    idle(2);

    // All-ones texels expand to all-ones block, visible one cycle after the 16th accept
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(i == 0, 24'h000123, 18'h3FFFF);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_block_data, {512{1'b1}});
    check("t1_addr", out_block_addr, 24'h000123);
    idle(2);

    // Bit-replication pattern at slot 5, zeros elsewhere
    for (int i = 0; i < 16; i++)
      send(i == 0, 24'h000777, (i == 5) ? {5'b10000, 6'b100000, 5'b00001, 2'b01} : 18'h0);
    mask = {512{1'b1}} ^ (512'hFFFFFFFF << 160);
    check("t2_slot5", out_block_data[191:160], 32'h55088284);
    check("t2_others", out_block_data & mask, 512'h0);
    idle(2);

    // Backpressure: 32 accepts, then held until drains begin
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int k = 0; k < 40; k++) begin
      drive_texel(acc_cnt);
      cycle(acc);
      if (acc) acc_cnt++;
    end
    check("bp_accepts", acc_cnt, 32);
    check("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    guard = 0;
    while (acc_cnt < 48 && guard < 200) begin
      drive_texel(acc_cnt);
      cycle(acc);
      if (acc) acc_cnt++;
      guard++;
    end
    check("bp_resume", acc_cnt, 48);
    in_valid = 1'b0;
    in_first = 1'b0;
    idle(3);

    // Sustained back-to-back intake
    d0 = drains;
    r0 = resyncs;
    for (int i = 0; i < 64; i++) send((i % 16) == 0, 24'h001000 + 24'(i / 16), 18'($urandom));
    idle(3);
    check("b2b_blocks", drains - d0, 4);
    check("b2b_resyncs", resyncs - r0, 0);

    // Mid-block in_first discards partial block and flags resync
    d0 = drains;
    r0 = resyncs;
    for (int i = 0; i < 7; i++) send(i == 0, 24'h000055, 18'($urandom));
    send(1'b1, 24'h0000AA, 18'h2A5A5);
    for (int i = 0; i < 15; i++) send(1'b0, 24'h0000AA, 18'($urandom));
    check("rs_valid", out_valid, 1'b1);
    check("rs_addr", out_block_addr, 24'h0000AA);
    check("rs_slot0", out_block_data[31:0], ref_expand(18'h2A5A5));
    idle(3);
    check("rs_pulses", resyncs - r0, 1);
    check("rs_blocks", drains - d0, 1);

    // Reset with one full buffer and a partial block pending
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) send((i % 16) == 0, 24'h002000 + 24'(i / 16), 18'($urandom));
    check("pre_rst_valid", out_valid, 1'b1);
    do_reset();
    d0 = drains;
    idle(1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(i == 0, 24'h003000, 18'($urandom));
    idle(3);
    check("post_rst_blocks", drains - d0, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/texture_block_packer_rgba8888.md
# texture_block_packer_rgba8888

Encoder-side counterpart of the FORMAT=5 texture decoder. Accepts a stream of RGBA5652 texels in 4x4-block row-major order and expands each to RGBA8888 by bit replication. Assembles 16 texels into one 512-bit block and presents it, with its block address, to the texture-memory write path. Sits between the render-to-texture / upload texel source and the SDRAM block writer. A ping-pong buffer lets texel intake continue while a completed block waits for the writer.

## Interface
Parameters:
- ADDR_W, 24, width of the block address carried alongside each block.

Ports:
- clk  in  1  core clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  texel present.
- in_ready  out  1  block can accept a texel this cycle.
- in_first  in  1  texel is index 0 of a new block; qualified by in_valid.
- in_block_addr  in  ADDR_W  block address; captured on an accepted in_first texel.
- in_rgba5652  in  18  {R5, G6, B5, A2}, R5 in [17:13].
- out_valid  out  1  completed block available.
- out_ready  in  1  writer accepts the block this cycle.
- out_block_data  out  512  texel t at [t*32 +: 32]; within each texel [7:0]=R8, [15:8]=G8, [23:16]=B8, [31:24]=A8.
- out_block_addr  out  ADDR_W  address of the presented block.
- resync_err  out  1  one-cycle pulse when a partial block is discarded.

## Operation
- A texel is accepted when in_valid && in_ready.
- Expansion of each accepted texel:
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
  - A8 = {A2, A2, A2, A2}
- Buffer state:
  - Two 512-bit data buffers and two address registers, each buffer with a full flag.
  - wr_sel selects the buffer being filled; rd_sel selects the buffer being presented.
  - A 4-bit texel counter cnt gives the write slot.
- Accept behaviour:
  - Each accepted texel writes slot cnt of buffer wr_sel, then cnt increments.
  - On an accepted texel with cnt==15: full[wr_sel] is set, wr_sel toggles and cnt wraps to 0.
- in_first handling:
  - Accepted in_first with cnt==0: in_block_addr is captured into addr[wr_sel].
  - Accepted in_first with cnt!=0: the partial block is discarded. The texel is written to slot 0, cnt becomes 1, the address is recaptured, and resync_err pulses the next cycle.
  - A texel with cnt==0 and in_first=0 is written normally. The address register keeps its previous value; this is the caller's error and is not flagged.
- in_ready = !full[wr_sel].
- out_valid = full[rd_sel]; out_block_data and out_block_addr are muxed from buffer rd_sel.
- Handshake rules:
  - When out_valid && out_ready: full[rd_sel] clears and rd_sel toggles.
  - out_block_data and out_block_addr are held stable while out_valid && !out_ready.
- Simultaneous fill-complete and drain always target different buffers, so both take effect in the same cycle.
- Blocks are emitted strictly in completion order.

## Timing
- Reset values: in_ready=1, out_valid=0, resync_err=0, cnt=0, wr_sel=rd_sel=0, full=2'b00.
  - Data and address buffers are not reset; out_block_data and out_block_addr are don't-care while out_valid=0.
- Throughput: 1 texel per cycle sustained when out_ready is 1 at least once every 16 cycles.
- Latency: 16th texel accepted at cycle N gives out_valid=1 at cycle N+1.
- in_ready is registered-derived; it has no combinational path from in_valid, and in_ready does not depend on out_ready in the same cycle.
  - Consequence: a drain at cycle N frees a buffer for intake at N+1.
- Backpressure: with out_ready=0, 32 texels are accepted, then in_ready=0 from the cycle after the 32nd.
- Reset mid-operation: all partial and complete blocks are dropped and the block returns to its reset values the cycle after rst_n is sampled low.

## Structure
- A shared texture package holds the texel field widths, TEXELS_PER_BLOCK=16, BLOCK_BITS=512, the RGBA8888 byte-lane offsets, and the 18-bit RGBA5652 field positions. The decoder uses the same package.
- One natural sub-module: texel_expand_5652_to_8888, purely combinational, 18 bits in and 32 bits out.
- The ping-pong buffer control stays in the top module.

## Test plan
- Sixteen texels of 18'h3FFFF, in_first on the first, addr=24'h000123, out_ready=1 -> one block of all 32'hFFFFFFFF, addr 24'h000123, with out_valid rising exactly one cycle after the 16th accept.
- Texel R5=5'b10000, G6=6'b100000, B5=5'b00001, A2=2'b01 at slot 5 -> bits [191:160] = 32'h55_08_82_84. The other slots are 0 when their input is 0.
- out_ready=0 with 40 texels offered -> in_ready falls after the 32nd accept and texel 33 is held. Raising out_ready then gives block A, then block B, in order with their addresses, and intake resumes one cycle after the first drain.
- 64 texels back-to-back with out_ready=1 -> in_ready never deasserts, 4 blocks are emitted at 16-cycle spacing, and resync_err stays 0.
- in_first asserted on texel 7 of a block with new addr 24'h0000AA -> resync_err pulses once, and the next emitted block has addr 24'h0000AA with the in_first texel in slot 0.
- rst_n low for one cycle with one full buffer and cnt=9 -> next cycle out_valid=0, in_ready=1, and the following 16 texels form a clean block.
